skew_aggregator: RTL and testbench

Parametrised de-skew stage at the output edge of the systolic matrix array. Collects an N×N result matrix streamed as anti-diagonal wavefronts on N packed lanes and reassembles it into a flat row-major matrix. Supports an optional transpose and ping-pong buffering so one frame can fill while the previous one drains. It replaces the fixed 4×4, externally-counted aggregator with an internally sequenced, flow-controlled block.

---
 rtl/lvg_pkg.sv | 32 +++
 rtl/skew_bank.sv | 66 ++++++
 rtl/skew_aggregator.sv | 114 +++++++++++
 tb/tb_skew_aggregator.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvg_pkg.sv
// Shared definitions for the systolic-array output de-skew stage.
// Wavefront geometry helpers are used both for elaboration-time lane
// decoding inside the register banks and for documentation of the format.
package lvg_pkg;

    localparam int LVG_N_DEFAULT = 4;
    localparam int LVG_W_DEFAULT = 32;

    // Number of populated lanes on wavefront beat t of an n x n frame.
    function automatic int wave_len(input int t, input int n);
        int rising;
        int falling;
        rising  = t + 1;
        falling = 2 * n - 1 - t;
        return (rising < falling) ? rising : falling;
    endfunction

    // Matrix row carried by lane k of wavefront beat t.
    function automatic int wave_row(input int t, input int k, input int n);
        int skew;
        skew = t - n + 1;
        return k + ((skew > 0) ? skew : 0);
    endfunction

    // Inverse mapping: lane on which logical element (i,j) arrives.
    // The element arrives on beat i+j; its lane is its row minus the
    // row carried by lane 0 on that beat.
    function automatic int wave_lane(input int i, input int j, input int n);
        return i - wave_row(i + j, 0, n);
    endfunction

endpackage

// File: rtl/skew_bank.sv
// One N x N x W register bank of the de-skew buffer.
// Each element captures exactly one lane on exactly one beat of a frame;
// the beat is fixed by the element position (r+c) and the lane is chosen
// by the frame's transpose flag, so both are resolved at elaboration.
module skew_bank
    import lvg_pkg::*;
#(
    parameter int N  = LVG_N_DEFAULT,
    parameter int W  = LVG_W_DEFAULT,
    parameter int TW = $clog2(2 * N - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [TW-1:0]    beat,
    input  logic             transpose,
    input  logic [N*W-1:0]   lane_data,
    output logic [N*N*W-1:0] bank_data
);

    logic [W-1:0]   elem_q   [N*N];
    logic [W-1:0]   elem_d   [N*N];
    logic [W-1:0]   elem_src [N*N];
    logic [N*N-1:0] elem_we;

    // Per-element write strobe and source lane, decoded from position.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            // Storage (r,c) holds logical (r,c) normally, logical (c,r)
            // when transposed; both arrive on beat r+c.
            localparam int BEAT      = r + c;
            localparam int LANE_STR  = wave_lane(r, c, N);
            localparam int LANE_TRN  = wave_lane(c, r, N);

            assign elem_we[r*N+c]  = wr_en && (beat == TW'(BEAT));
            assign elem_src[r*N+c] = transpose ? lane_data[LANE_TRN*W +: W]
                                               : lane_data[LANE_STR*W +: W];
            assign bank_data[(r*N+c)*W +: W] = elem_q[r*N+c];
        end
    end

    // Next element values: load the selected lane on its beat, else hold.
    always_comb begin
        // NOTE: every path assigns elem_d, so no latch can be inferred.
        for (int e = 0; e < N * N; e++) begin
            elem_d[e] = elem_we[e] ? elem_src[e] : elem_q[e];
        end
    end

    // Element storage; cleared on reset so the output reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this array is reset on purpose: out_data must read 0
            // after reset, so it cannot be left as an unreset RAM.
            for (int e = 0; e < N * N; e++) begin
                elem_q[e] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignment for all sequential state.
            for (int e = 0; e < N * N; e++) begin
                elem_q[e] <= elem_d[e];
            end
        end
    end

endmodule

// File: rtl/skew_aggregator.sv
// Output-edge de-skew stage for the systolic matrix array.
// Accepts 2N-1 anti-diagonal wavefront beats per frame, writes them into
// one of two ping-pong banks and presents completed matrices row-major.
// in_ready depends only on registered state, never on out_ready.
module skew_aggregator
    import lvg_pkg::*;
#(
    parameter int N = LVG_N_DEFAULT,
    parameter int W = LVG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_transpose,
    input  logic [N*W-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*N*W-1:0] out_data
);

    localparam int TW   = $clog2(2 * N - 1);
    localparam int LAST = 2 * N - 2;

    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    full_q,   full_d;
    logic [TW-1:0] tcnt_q,   tcnt_d;
    logic          tmode_q,  tmode_d;

    logic          accept;
    logic          drain;
    logic          last_beat;
    logic          beat_transpose;
    logic [1:0]    bank_we;
    logic [N*N*W-1:0] bank_data [2];

    assign in_ready  = !full_q[wr_ptr_q];
    assign out_valid = full_q[rd_ptr_q];
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last_beat = (tcnt_q == TW'(LAST));

    // Beat 0 uses the live flag; later beats reuse the one latched on beat 0.
    assign beat_transpose = (tcnt_q == '0) ? in_transpose : tmode_q;

    assign bank_we[0] = accept && !wr_ptr_q;
    assign bank_we[1] = accept &&  wr_ptr_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        skew_bank #(
            .N  (N),
            .W  (W),
            .TW (TW)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (bank_we[b]),
            .beat      (tcnt_q),
            .transpose (beat_transpose),
            .lane_data (in_data),
            .bank_data (bank_data[b])
        );
    end

    assign out_data = rd_ptr_q ? bank_data[1] : bank_data[0];

    // Sequencing: beat counter, frame completion and drain bookkeeping.
    always_comb begin
        tcnt_d   = tcnt_q;
        tmode_d  = tmode_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;

        if (accept) begin
            if (tcnt_q == '0) begin
                tmode_d = in_transpose;
            end
            if (last_beat) begin
                tcnt_d           = '0;
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = !wr_ptr_q;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end

        // Completion targets an empty bank and drain a full one, so the
        // two never collide when they land in the same cycle.
        if (drain) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = !rd_ptr_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q   <= '0;
            tmode_q  <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            full_q   <= '0;
        end else begin
            tcnt_q   <= tcnt_d;
            tmode_q  <= tmode_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
        end
    end

endmodule

// File: tb/tb_skew_aggregator.sv
// Self-checking bench for skew_aggregator: directed vector table,
// hand-written multi-cycle sequences and a randomized model comparison.
module tb_skew_aggregator;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int DW = N * W;
    localparam int MW = N * N * W;
    localparam int F  = 2 * N - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_transpose = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [MW-1:0] out_data;

    logic          in_valid2 = 1'b0;
    logic          in_ready2;
    logic          in_transpose2 = 1'b0;
    logic [15:0]   in_data2 = '0;
    logic          out_valid2;
    logic          out_ready2 = 1'b1;
    logic [31:0]   out_data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skew_aggregator #(.N(N), .W(W)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_transpose (in_transpose),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    skew_aggregator #(.N(2), .W(8)) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .in_transpose (in_transpose2),
        .in_data      (in_data2),
        .out_valid    (out_valid2),
        .out_ready    (out_ready2),
        .out_data     (out_data2)
    );

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lanes of beat t of a frame whose element (r,c) holds base + N*r + c;
    // unused lanes carry junk that must be ignored.
    function automatic logic [DW-1:0] make_beat(input int t, input int base);
        logic [DW-1:0] d;
        int len;
        int row;
        len = (t + 1 < F - t) ? t + 1 : F - t;
        for (int k = 0; k < N; k++) begin
            if (k < len) begin
                row = k + ((t - N + 1 > 0) ? t - N + 1 : 0);
                d[k*W +: W] = W'(base + N * row + (t - row));
            end else begin
                d[k*W +: W] = 32'hDEAD_0000 + W'(k);
            end
        end
        return d;
    endfunction

    function automatic logic [MW-1:0] exp_matrix(input int base, input bit tr);
        logic [MW-1:0] m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[(r*N+c)*W +: W] = tr ? W'(base + N * c + r) : W'(base + N * r + c);
        return m;
    endfunction

    typedef struct {
        logic          vld;
        logic          tr;
        logic [DW-1:0] data;
        logic          exp_in_ready;
        logic          exp_out_valid;
        logic          chk_data;
        logic [MW-1:0] exp_data;
    } vec_t;

    vec_t vecs[16];

    // Model state for the randomized phase.
    logic [W-1:0]  cur [N][N];
    int            mt;
    bit            mtr;
    logic [MW-1:0] done_q [$];

    initial begin
        int lane_vals [7][4];
        logic [MW-1:0] mat_a;
        logic [MW-1:0] mat_t;
        logic [MW-1:0] packed_m;

        lane_vals = '{'{0, -1, -1, -1}, '{1, 4, -1, -1}, '{2, 5, 8, -1},
                      '{3, 6, 9, 12}, '{7, 10, 13, -1}, '{11, 14, -1, -1},
                      '{15, -1, -1, -1}};
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mat_a[(r*N+c)*W +: W] = W'(r * N + c);
                mat_t[(r*N+c)*W +: W] = W'(c * N + r);
            end

        for (int f = 0; f < 2; f++) begin
            for (int t = 0; t < 8; t++) begin
                vec_t v;
                v.vld = (t < 7);
                v.tr  = (f == 1 && t == 0);
                v.data = '0;
                if (t < 7)
                    for (int k = 0; k < N; k++)
                        v.data[k*W +: W] = (lane_vals[t][k] < 0) ? 32'hBAD0_0000 + W'(k)
                                                                  : W'(lane_vals[t][k]);
                v.exp_in_ready  = 1'b1;
                v.exp_out_valid = (t == 7);
                v.chk_data      = (t == 7);
                v.exp_data      = (f == 1) ? mat_t : mat_a;
                vecs[f*8+t] = v;
            end
        end

        // Reset state of both instances.
        #2;
        @(negedge clk);
        check("rst_in_ready", MW'(in_ready), MW'(1));
        check("rst_out_valid", MW'(out_valid), MW'(0));
        check("rst_out_data", out_data, '0);
        check("rst2_in_ready", MW'(in_ready2), MW'(1));
        check("rst2_out_valid", MW'(out_valid2), MW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Plain and transposed frames from the vector table.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid     = vecs[i].vld;
            in_transpose = vecs[i].tr;
            in_data      = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), MW'(in_ready), MW'(vecs[i].exp_in_ready));
            check($sformatf("vec%0d_out_valid", i), MW'(out_valid), MW'(vecs[i].exp_out_valid));
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
            if (i == 15) begin
                check("tr_word1", MW'(out_data[1*W +: W]), MW'(4));
                check("tr_word4", MW'(out_data[4*W +: W]), MW'(1));
            end
            tick();
        end
        in_valid = 1'b0;

        // Two back-to-back frames with the consumer stalled.
        out_ready = 1'b0;
        for (int b = 0; b < 2 * F; b++) begin
            in_valid = 1'b1;
            in_data  = make_beat(b % F, (b < F) ? 0 : 'h100);
            @(negedge clk);
            check($sformatf("bb_ready_beat%0d", b), MW'(in_ready), MW'(1));
            check($sformatf("bb_valid_beat%0d", b), MW'(out_valid), MW'(b >= F));
            tick();
        end
        in_data = make_beat(0, 'h200);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check($sformatf("stall%0d_in_ready", s), MW'(in_ready), MW'(0));
            check($sformatf("stall%0d_out_valid", s), MW'(out_valid), MW'(1));
            check($sformatf("stall%0d_out_data", s), out_data, exp_matrix(0, 1'b0));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("pulse_in_ready", MW'(in_ready), MW'(0));
        check("pulse_out_data", out_data, exp_matrix(0, 1'b0));
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("second_out_valid", MW'(out_valid), MW'(1));
        check("second_out_data", out_data, exp_matrix('h100, 1'b0));
        check("second_in_ready", MW'(in_ready), MW'(1));
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("drained_out_valid", MW'(out_valid), MW'(0));
        tick();

        // Frame with three idle cycles between beats.
        for (int t = 0; t < F; t++) begin
            in_valid = 1'b1;
            in_data  = make_beat(t, 0);
            @(negedge clk);
            check($sformatf("gap_valid_beat%0d", t), MW'(out_valid), MW'(0));
            tick();
            in_valid = 1'b0;
            if (t < F - 1)
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    check($sformatf("gap_valid_idle%0d_%0d", t, g), MW'(out_valid), MW'(0));
                    tick();
                end
        end
        @(negedge clk);
        check("gap_out_valid", MW'(out_valid), MW'(1));
        check("gap_out_data", out_data, exp_matrix(0, 1'b0));
        tick();

        // Reset in the middle of a frame.
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1;
            in_data  = make_beat(t, 'h300);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", MW'(out_valid), MW'(0));
        check("midrst_out_data", out_data, '0);
        check("midrst_in_ready", MW'(in_ready), MW'(1));
        tick();
        rst = 1'b0;
        for (int t = 0; t < F; t++) begin
            in_valid = 1'b1;
            in_data  = make_beat(t, 'h10);
            @(negedge clk);
            check($sformatf("fresh_valid_beat%0d", t), MW'(out_valid), MW'(0));
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("fresh_out_valid", MW'(out_valid), MW'(1));
        check("fresh_out_data", out_data, exp_matrix('h10, 1'b0));
        tick();

        // Small 2x2 instance.
        in_valid2 = 1'b1;
        in_data2  = {8'h5A, 8'hA1};
        tick();
        in_data2  = {8'hC3, 8'hB2};
        tick();
        in_data2  = {8'h6B, 8'hD4};
        tick();
        in_valid2 = 1'b0;
        @(negedge clk);
        check("n2_out_valid", MW'(out_valid2), MW'(1));
        check("n2_out_data", MW'(out_data2), MW'(32'hD4C3_B2A1));
        tick();

        // Randomized traffic against a frame-level model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done_q.delete();
        mt  = 0;
        mtr = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit acc;
            bit drn;
            in_valid     = ($urandom_range(0, 9) < 7);
            out_ready    = ($urandom_range(0, 1) == 1);
            in_transpose = $urandom_range(0, 1);
            for (int k = 0; k < N; k++)
                in_data[k*W +: W] = $urandom;
            @(negedge clk);
            check("rnd_in_ready", MW'(in_ready), MW'(done_q.size() < 2));
            check("rnd_out_valid", MW'(out_valid), MW'(done_q.size() > 0));
            if (done_q.size() > 0)
                check("rnd_out_data", out_data, done_q[0]);
            acc = in_valid && (done_q.size() < 2);
            drn = out_ready && (done_q.size() > 0);
            if (drn)
                void'(done_q.pop_front());
            if (acc) begin
                int len;
                int row;
                int col;
                if (mt == 0)
                    mtr = in_transpose;
                len = (mt + 1 < F - mt) ? mt + 1 : F - mt;
                for (int k = 0; k < len; k++) begin
                    row = k + ((mt - N + 1 > 0) ? mt - N + 1 : 0);
                    col = mt - row;
                    if (mtr)
                        cur[col][row] = in_data[k*W +: W];
                    else
                        cur[row][col] = in_data[k*W +: W];
                end
                mt++;
                if (mt == F) begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            packed_m[(r*N+c)*W +: W] = cur[r][c];
                    done_q.push_back(packed_m);
                    mt = 0;
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
